// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: PC, req/ack instruction-memory port, valid/ready issue to decode.
// Optional misaligned-redirect trap (fetch_fault, FAULT state) enabled by IFU_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic              fetch_fault
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    FAULT = 3'd4
`endif
  } state_t;

  state_t            state_r;
  state_t            redirTarget_s;
  state_t            drainTarget_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] redirPc_s;
  logic [ADDR_W-1:0] pcPlus4_s;
`ifdef IFU_MISALIGN_CHECK_EN
  logic              misaligned_s;
  logic              drainFault_r;
`endif

  assign opcode    = instr[31:26];
  assign pcPlus4_s = pc_r + ADDR_W'(32'd4);

  // Redirect target address and the state reached once any outstanding request is retired.
  always_comb begin
`ifdef IFU_MISALIGN_CHECK_EN
    redirPc_s     = redirect_pc;
    misaligned_s  = (redirect_pc[1:0] != 2'b00);
    redirTarget_s = misaligned_s ? FAULT : FETCH;
    drainTarget_s = drainFault_r ? FAULT : FETCH;
`else
    redirPc_s     = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
    redirTarget_s = FETCH;
    drainTarget_s = FETCH;
`endif
  end

  // Fetch FSM with all handshake and instruction outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= 32'h0000_0000;
      instr_pc    <= {ADDR_W{1'b0}};
      instr_valid <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      fetch_fault  <= 1'b0;
      drainFault_r <= 1'b0;
`endif
    end else if (redirect) begin
      pc_r        <= redirPc_s;
      instr_valid <= 1'b0;
      // An unacknowledged request keeps its address; the new PC waits behind the ack.
      if ((state_r == FETCH || state_r == DRAIN) && !imem_ack) begin
        state_r <= DRAIN;
`ifdef IFU_MISALIGN_CHECK_EN
        drainFault_r <= misaligned_s;
`endif
      end else begin
        state_r   <= redirTarget_s;
        imem_req  <= (redirTarget_s == FETCH);
        imem_addr <= redirPc_s;
`ifdef IFU_MISALIGN_CHECK_EN
        fetch_fault  <= (redirTarget_s == FAULT);
        drainFault_r <= 1'b0;
`endif
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r   <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc_r;
        end
        FETCH: begin
          if (imem_ack) begin
            state_r     <= ISSUE;
            instr       <= imem_rdata;
            instr_pc    <= pc_r;
            pc_r        <= pcPlus4_s;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            state_r     <= FETCH;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= pc_r;
          end else begin
            instr_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state_r   <= drainTarget_s;
            imem_req  <= (drainTarget_s == FETCH);
            imem_addr <= pc_r;
`ifdef IFU_MISALIGN_CHECK_EN
            fetch_fault  <= (drainTarget_s == FAULT);
            drainFault_r <= 1'b0;
`endif
          end else begin
            imem_req <= 1'b1;
          end
        end
`ifdef IFU_MISALIGN_CHECK_EN
        FAULT: begin
          imem_req    <= 1'b0;
          fetch_fault <= 1'b1;
        end
`endif
        default: begin
          state_r     <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
